window_allocator: RTL and testbench

One allocator slot on the receive side of the Issue unit's broadcast pixel stream. It is armed by a positioner select with a window centre and captures every broadcast pixel that falls inside its (2h+1)×(2h+1) window, one depth plane at a time. When a plane is complete, it raises its `issue_block` bit and drains the plane in raster order to the downstream MAC over a valid/ready stream. One instance exists per bit of the Issue unit's `num_allocators` vector.

---
 rtl/window_allocator.sv | 185 ++++++++++++++++++
 tb/tb_window_allocator.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_allocator.sv
// rtl/window_allocator.sv - one allocator slot: captures a (2h+1)^2 window of broadcast pixels per plane, then drains it in raster order
// Optional edge zero padding is enabled by defining ALLOC_ZERO_PAD_EN.
module window_allocator #(
   parameter int data_width   = 8,
   parameter int max_halfsize = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            image_dim,
   input  logic [8:0]            image_depth,
   input  logic [1:0]            filter_halfsize,
   input  logic [7:0]            positioner_x,
   input  logic [7:0]            positioner_y,
   input  logic                  positioner_select,
   input  logic [7:0]            issue_x,
   input  logic [7:0]            issue_y,
   input  logic [data_width-1:0] issue_data,
   input  logic                  issue_en,
   output logic                  issue_block,
   output logic [data_width-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [8:0]            out_plane,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int max_side  = 2 * max_halfsize + 1;
   localparam int max_cells = max_side * max_side;
   localparam int ptr_w     = $clog2(max_cells);

   typedef enum logic [1:0] {st_idle, st_fill, st_drain} state_t;
   state_t state, state_next;

   logic [data_width-1:0] cells [max_cells];
   logic [max_cells-1:0]  valid, pad, valid_fill, need_mask, pad_arm, pad_restart;
   logic [7:0]            x0, y0;
   logic [1:0]            h;
   logic [8:0]            plane;
   logic [ptr_w-1:0]      rd_ptr, wr_idx, n_cells, side_u;
   logic [9:0]            depth_eff;
   logic                  pad_en, in_win, window_full, handshake, at_last, more_planes;
   logic signed [9:0]     dx, dy, hs, side_s;

   function automatic logic [max_cells-1:0] count_mask(input logic [ptr_w-1:0] n);
      logic [max_cells-1:0] m;
      for (int i = 0; i < max_cells; i++) m[i] = (i < int'(n));
      return m;
   endfunction

   // Cells of the window whose image coordinate falls outside 0..dim-1.
   function automatic logic [max_cells-1:0] off_image(input logic [7:0] cx, input logic [7:0] cy,
                                                       input logic [1:0] ch, input logic [7:0] dim);
      logic [max_cells-1:0] m;
      logic [ptr_w-1:0]     idx;
      int                   side, px, py;
      m    = '0;
      side = 2 * int'(ch) + 1;
      for (int r = 0; r < max_side; r++) begin
         for (int c = 0; c < max_side; c++) begin
            px  = int'(cx) - int'(ch) + c;
            py  = int'(cy) - int'(ch) + r;
            idx = ptr_w'(r * side + c);
            if (r < side && c < side && (px < 0 || py < 0 || px >= int'(dim) || py >= int'(dim)))
               m[idx] = 1'b1;
         end
      end
      return m;
   endfunction

   always_comb begin
`ifdef ALLOC_ZERO_PAD_EN
      pad_en = 1'b1;
`else
      pad_en = 1'b0;
`endif
      pad_arm     = pad_en ? off_image(positioner_x, positioner_y, filter_halfsize, image_dim) : '0;
      pad_restart = pad_en ? off_image(x0, y0, h, image_dim) : '0;
   end

   // 10-bit signed offsets so centres near 0 or 255 never wrap.
   assign hs     = $signed({8'b0, h});
   assign side_s = $signed({7'b0, h, 1'b1});
   assign dx     = $signed({2'b0, issue_x}) - $signed({2'b0, x0});
   assign dy     = $signed({2'b0, issue_y}) - $signed({2'b0, y0});
   assign in_win = (dx >= -hs) && (dx <= hs) && (dy >= -hs) && (dy <= hs);
   assign wr_idx = ptr_w'((dy + hs) * side_s + (dx + hs));

   always_comb begin
      valid_fill = valid;
      if (issue_en && in_win) valid_fill[wr_idx] = 1'b1;
   end

   assign side_u      = {{(ptr_w-3){1'b0}}, h, 1'b1};
   assign n_cells     = side_u * side_u;
   assign need_mask   = count_mask(n_cells);
   assign window_full = (valid_fill & need_mask) == need_mask;
   assign handshake   = out_valid && out_ready;
   assign at_last     = (rd_ptr == n_cells - ptr_w'(1));
   assign depth_eff   = (image_depth == 9'd0) ? 10'd1 : {1'b0, image_depth};
   assign more_planes = ({1'b0, plane} + 10'd1) < depth_eff;

   always_ff @(posedge clk) begin
      if (rst) state <= st_idle;
      else     state <= state_next;
   end

   always_comb begin
      state_next  = state;
      issue_block = 1'b0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      out_data    = '0;
      busy        = (state != st_idle);
      case (state)
         st_idle:  if (positioner_select) state_next = st_fill;
         st_fill:  if (window_full) state_next = st_drain;
         st_drain: begin
            issue_block = 1'b1;
            out_valid   = 1'b1;
            out_last    = at_last;
            out_data    = pad[rd_ptr] ? '0 : cells[rd_ptr];
            if (handshake && at_last) state_next = more_planes ? st_fill : st_idle;
         end
         default:  state_next = st_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid  <= '0;
         pad    <= '0;
         x0     <= '0;
         y0     <= '0;
         h      <= '0;
         plane  <= '0;
         rd_ptr <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (positioner_select && state != st_idle) err <= 1'b1;
         case (state)
            st_idle: begin
               if (positioner_select) begin
                  x0     <= positioner_x;
                  y0     <= positioner_y;
                  h      <= filter_halfsize;
                  valid  <= pad_arm;
                  pad    <= pad_arm;
                  plane  <= '0;
                  rd_ptr <= '0;
               end
            end
            st_fill: valid <= valid_fill;
            st_drain: begin
               if (handshake) begin
                  if (at_last) begin
                     rd_ptr <= '0;
                     if (more_planes) begin
                        plane <= plane + 9'd1;
                        valid <= pad_restart;
                        pad   <= pad_restart;
                     end else begin
                        done  <= 1'b1;
                        valid <= '0;
                     end
                  end else begin
                     rd_ptr <= rd_ptr + ptr_w'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Window storage needs no reset: a cell is only read once its valid bit is set.
   always_ff @(posedge clk) begin
      if (state == st_fill && issue_en && in_win) cells[wr_idx] <= issue_data;
   end

   assign out_plane = plane;
endmodule

// File: tb/tb_window_allocator.sv
// tb/tb_window_allocator.sv - self-checking bench for window_allocator
// Expectations follow the ALLOC_ZERO_PAD_EN setting of the build.
module tb_window_allocator;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] image_dim;
   logic [8:0] image_depth;
   logic [1:0] filter_halfsize;
   logic [7:0] positioner_x, positioner_y;
   logic       positioner_select;
   logic [7:0] issue_x, issue_y, issue_data;
   logic       issue_en, issue_block;
   logic [7:0] out_data;
   logic       out_valid, out_ready, out_last;
   logic [8:0] out_plane;
   logic       busy, done, err;

   always #5 clk = ~clk;

   window_allocator #(.data_width(8), .max_halfsize(3)) dut (
      .clk(clk), .rst(rst), .image_dim(image_dim), .image_depth(image_depth),
      .filter_halfsize(filter_halfsize), .positioner_x(positioner_x), .positioner_y(positioner_y),
      .positioner_select(positioner_select), .issue_x(issue_x), .issue_y(issue_y),
      .issue_data(issue_data), .issue_en(issue_en), .issue_block(issue_block),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .out_plane(out_plane), .busy(busy), .done(done), .err(err)
   );

   typedef struct { logic [7:0] data; logic last; logic [8:0] plane; logic fin; } cell_t;
   typedef struct { int x0; int y0; int h; int depth; int dim; int exp_cells; int exp_done; } case_t;

   cell_t sb[$];
   case_t cases[6];
   int    checks = 0, errors = 0;
   int    done_count = 0, block_cycles = 0, tog = 0;
   logic  done_pending = 1'b0, stall_prev = 1'b0, toggle_en = 1'b0;
   logic [7:0] stall_data = '0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int x, input int y, input int p);
      return 8'(x * 5 + y * 11 + p * 37 + 1);
   endfunction

   task automatic push_window(input int x0, input int y0, input int h, input int depth, input int dim);
      int side, dep, x, y;
      cell_t e;
      side = 2 * h + 1;
      dep  = (depth == 0) ? 1 : depth;
      for (int p = 0; p < dep; p++)
         for (int r = 0; r < side; r++)
            for (int c = 0; c < side; c++) begin
               x = x0 - h + c;
               y = y0 - h + r;
               e.data  = (x < 0 || y < 0 || x >= dim || y >= dim) ? 8'd0 : pix(x, y, p);
               e.last  = (r == side - 1) && (c == side - 1);
               e.plane = 9'(p);
               e.fin   = e.last && (p == dep - 1);
               sb.push_back(e);
            end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle_en) begin
         tog++;
         out_ready = (tog % 4 == 0) || (tog % 4 == 3);
      end
   endtask

   task automatic select(input int x, input int y, input int h, input int depth, input int dim);
      image_dim         = 8'(dim);
      image_depth       = 9'(depth);
      filter_halfsize   = 2'(h);
      positioner_x      = 8'(x);
      positioner_y      = 8'(y);
      positioner_select = 1'b1;
      tick();
      positioner_select = 1'b0;
   endtask

   task automatic send_pix(input int x, input int y, input logic [7:0] d);
      issue_x = 8'(x); issue_y = 8'(y); issue_data = d; issue_en = 1'b1;
      tick();
      issue_en = 1'b0;
   endtask

   task automatic drive_plane(input int p, input int dim);
      for (int y = 0; y < dim; y++)
         for (int x = 0; x < dim; x++) begin
            if (issue_block) begin
               issue_en = 1'b0;
               return;
            end
            issue_x = 8'(x); issue_y = 8'(y); issue_data = pix(x, y, p); issue_en = 1'b1;
            tick();
         end
      issue_en = 1'b0;
   endtask

   task automatic wait_block_low(input int limit);
      int n = 0;
      while (issue_block && n < limit) begin tick(); n++; end
      check("wait_block_low_timeout", issue_block, 0);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin tick(); n++; end
      check("wait_idle_timeout", busy, 0);
      tick();
   endtask

   always @(negedge clk) begin
      cell_t e;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (done) done_count++;
         if (issue_block) block_cycles++;
         if (done_pending) begin
            check("done_after_last", done, 1);
            done_pending = 1'b0;
         end
         if (stall_prev && out_valid) check("stall_hold", out_data, stall_data);
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cell: got data %0d plane %0d, expected no output", out_data, out_plane);
            end else begin
               e = sb.pop_front();
               check("cell_data", out_data, e.data);
               check("cell_last", out_last, e.last);
               check("cell_plane", out_plane, e.plane);
               if (e.fin) done_pending = 1'b1;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      cell_t tmp;
      case_t c;
      rst = 1'b1; out_ready = 1'b1; issue_en = 1'b0; positioner_select = 1'b0;
      issue_x = '0; issue_y = '0; issue_data = '0; positioner_x = '0; positioner_y = '0;
      image_dim = 8'd16; image_depth = 9'd1; filter_halfsize = 2'd1;

      cases[0] = '{12, 12, 1, 1, 25, 9, 1};
      cases[1] = '{5, 7, 2, 3, 16, 75, 1};
      cases[2] = '{3, 3, 0, 1, 8, 1, 1};
      cases[3] = '{8, 8, 3, 0, 16, 49, 1};
`ifdef ALLOC_ZERO_PAD_EN
      cases[4] = '{0, 0, 1, 1, 8, 9, 1};
      cases[5] = '{15, 15, 2, 2, 16, 50, 1};
`else
      cases[4] = '{0, 0, 1, 1, 8, 0, 0};
      cases[5] = '{15, 15, 2, 2, 16, 0, 0};
`endif

      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_issue_block", issue_block, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_out_plane", out_plane, 0);
      check("rst_out_data", out_data, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         c = cases[i];
         done_count = 0; block_cycles = 0;
         if (c.exp_done != 0) push_window(c.x0, c.y0, c.h, c.depth, c.dim);
         select(c.x0, c.y0, c.h, c.depth, c.dim);
         check("busy_after_select", busy, 1);
         if (c.exp_done != 0) begin
            for (int p = 0; p < ((c.depth == 0) ? 1 : c.depth); p++) begin
               drive_plane(p, c.dim);
               wait_block_low(100);
            end
            wait_idle(20);
            check("done_count", done_count, c.exp_done);
            check("block_cycles", block_cycles, c.exp_cells);
            check("sb_empty", sb.size(), 0);
         end else begin
            drive_plane(0, c.dim);
            tick();
            check("stuck_busy", busy, 1);
            check("stuck_block", block_cycles, 0);
            check("stuck_no_done", done_count, 0);
            rst = 1'b1; tick(); rst = 1'b0; tick();
         end
      end

      // Drain with out_ready toggling 1,0,0,1
      done_count = 0;
      push_window(6, 5, 1, 1, 12);
      toggle_en = 1'b1;
      select(6, 5, 1, 1, 12);
      drive_plane(0, 12);
      wait_block_low(100);
      wait_idle(20);
      toggle_en = 1'b0; out_ready = 1'b1;
      check("stall_done_count", done_count, 1);
      check("stall_sb_empty", sb.size(), 0);

      // Stray select mid-FILL must not disturb the window in progress
      done_count = 0;
      push_window(6, 6, 1, 1, 12);
      select(6, 6, 1, 1, 12);
      for (int x = 0; x < 12; x++) send_pix(x, 0, pix(x, 0, 0));
      positioner_x = 8'd2; positioner_y = 8'd2; filter_halfsize = 2'd2; positioner_select = 1'b1;
      tick();
      positioner_select = 1'b0;
      check("err_set", err, 1);
      check("err_busy", busy, 1);
      drive_plane(0, 12);
      wait_idle(20);
      check("err_done_count", done_count, 1);
      check("err_sb_empty", sb.size(), 0);
      check("err_sticky", err, 1);

      // Reset during the second plane's drain
      push_window(6, 6, 1, 2, 12);
      select(6, 6, 1, 2, 12);
      drive_plane(0, 12);
      wait_block_low(100);
      drive_plane(1, 12);
      tick(); tick();
      check("pre_rst_plane", out_plane, 1);
      rst = 1'b1;
      tick();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_issue_block", issue_block, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_last", out_last, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_out_plane", out_plane, 0);
      check("mid_rst_out_data", out_data, 0);
      rst = 1'b0;
      sb.delete();
      done_pending = 1'b0;
      tick();

      // Repeated coordinate: last value wins, completion needs all distinct cells
      done_count = 0;
      push_window(4, 4, 1, 1, 12);
      tmp = sb[4]; tmp.data = 8'd9; sb[4] = tmp;
      select(4, 4, 1, 1, 12);
      send_pix(4, 4, 8'd5);
      for (int r = 0; r < 3; r++)
         for (int cc = 0; cc < 3; cc++) begin
            if (r == 2 && cc == 2) continue;
            if (r == 1 && cc == 1) send_pix(4, 4, 8'd9);
            else send_pix(3 + cc, 3 + r, pix(3 + cc, 3 + r, 0));
         end
      check("dup_not_full_block", issue_block, 0);
      check("dup_not_full_busy", busy, 1);
      send_pix(5, 5, pix(5, 5, 0));
      check("dup_complete_block", issue_block, 1);
      check("dup_complete_valid", out_valid, 1);
      wait_idle(20);
      check("dup_done_count", done_count, 1);
      check("dup_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
